// File: rtl/pipeline_rr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_rr_issuer
// Purpose  : Round-robin issue controller sharing one fixed-latency,
//            non-stallable pipeline among NUM_REQ requesters. Grants at most
//            one requester per cycle and drives the pipeline input. A tag
//            shift register as deep as the pipeline carries each item's
//            requester ID, so every result returns tagged with its owner.
// Ports    : _i_clk, _i_rst_n    clock, asynchronous active-low reset
//            _i_enable           issue enable (low = no grants)
//            _i_req_valid/_data  per-requester request and payload
//            __req_ready         one-hot grant
//            __pipe_in/_valid    pipeline input and issue strobe
//            _i_pipe_out         pipeline output (LATENCY cycles later)
//            __resp_valid/_id    result valid and owning requester
//            __resp_data         pipeline output, passed through
//            __issued_count      wrapping count of issued items
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_rr_issuer #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      _i_clk,
  input  logic                      _i_rst_n,
  input  logic                      _i_enable,
  input  logic [NUM_REQ-1:0]        _i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] _i_req_data,
  output logic [NUM_REQ-1:0]        __req_ready,
  output logic [DATA_W-1:0]         __pipe_in,
  output logic                      __pipe_valid,
  input  logic [DATA_W-1:0]         _i_pipe_out,
  output logic                      __resp_valid,
  output logic [ID_W-1:0]           __resp_id,
  output logic [DATA_W-1:0]         __resp_data,
  output logic [15:0]               __issued_count
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  localparam logic [ID_W:0]   c_num_req_ext = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last_id     = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]               r_ptr;
  logic [15:0]                   r_issued_count;
  logic [LATENCY-1:0]            r_tag_vld;
  logic [LATENCY-1:0][ID_W-1:0]  r_tag_id;

  logic                          w_found;
  logic [ID_W-1:0]               w_gid;
  logic [ID_W:0]                 w_idx;

  // Search ptr, ptr+1, ... (mod NUM_REQ); first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    if (_i_enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
        if (w_idx >= c_num_req_ext) begin
          w_idx = w_idx - c_num_req_ext;
        end
        if (!w_found && _i_req_valid[w_idx[ID_W-1:0]]) begin
          w_found = 1'b1;
          w_gid   = w_idx[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    __req_ready = '0;
    __pipe_in   = '0;
    if (w_found) begin
      __req_ready[w_gid] = 1'b1;
      __pipe_in          = _i_req_data[w_gid*DATA_W +: DATA_W];
    end
  end

  assign __pipe_valid = w_found;

  // Pointer moves just past the winner, so the winner becomes lowest priority.
  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      r_ptr          <= '0;
      r_issued_count <= '0;
    end else if (w_found) begin
      r_ptr          <= (w_gid == c_last_id) ? '0 : w_gid + 1'b1;
      r_issued_count <= r_issued_count + 16'd1;
    end
  end

  // Tag pipeline: shifts every cycle, bubbles included, mirroring the
  // non-stallable datapath so tail lines up with _i_pipe_out.
  generate
    if (LATENCY == 1) begin : g_tag_single
      always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld[0] <= w_found;
          r_tag_id[0]  <= w_gid;
        end
      end
    end else begin : g_tag_shift
      always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld <= {r_tag_vld[LATENCY-2:0], w_found};
          r_tag_id  <= {r_tag_id[LATENCY-2:0], w_gid};
        end
      end
    end
  endgenerate

  assign __resp_valid   = r_tag_vld[LATENCY-1];
  assign __resp_id      = r_tag_id[LATENCY-1];
  assign __resp_data    = _i_pipe_out;
  assign __issued_count = r_issued_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_rr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_rr_issuer
// Purpose  : Directed self-checking bench for pipeline_rr_issuer with a
//            3-stage delay pipeline closing the loop from pipe_in to pipe_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_rr_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  pipe_in;
  logic        pipe_valid;
  logic [7:0]  pipe_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data;
  logic [15:0] issued_count;

  // Preloaded nonzero so the reset check sees live pipeline data.
  logic [7:0]  p0 = 8'h5A, p1 = 8'h5A, p2 = 8'h5A;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p0 <= pipe_in;
    p1 <= p0;
    p2 <= p1;
  end
  assign pipe_out = p2;

  pipeline_rr_issuer #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .LATENCY (3),
    .ID_W    (2)
  ) dut (
    ._i_clk         (clk),
    ._i_rst_n       (rst_n),
    ._i_enable      (enable),
    ._i_req_valid   (req_valid),
    ._i_req_data    (req_data),
    .__req_ready    (req_ready),
    .__pipe_in      (pipe_in),
    .__pipe_valid   (pipe_valid),
    ._i_pipe_out    (pipe_out),
    .__resp_valid   (resp_valid),
    .__resp_id      (resp_id),
    .__resp_data    (resp_data),
    .__issued_count (issued_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    req_valid = '0;
    rst_n     = 1'b0;
    step();
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'h0 || pipe_valid !== 1'b0 || pipe_in !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_grant: ready=%b valid=%b pipe_in=%h, want 0000/0/00",
               req_ready, pipe_valid, pipe_in);
    end
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0 || issued_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_resp: resp_valid=%b id=%0d count=%0d, want 0/0/0",
               resp_valid, resp_id, issued_count);
    end
    n_cmp++;
    if (resp_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_passthru: resp_data=%h, want 5a", resp_data);
    end
    step();
    step();
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_c%0d: resp_valid=%b, want 0", c, resp_valid);
      end
    end
  endtask

  task automatic test_single();
    step();
    req_valid = 4'b0010;
    req_data  = 32'h0000_1100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010 || pipe_in !== 8'h11 || pipe_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: ready=%b pipe_in=%h valid=%b, want 0010/11/1",
               req_ready, pipe_in, pipe_valid);
    end
    step();
    req_valid = '0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000 || pipe_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: ready=%b valid=%b, want 0000/0", req_ready, pipe_valid);
    end
    step();
    step();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'h11) begin
      n_fail++;
      $display("FAIL single_resp: valid=%b id=%0d data=%h, want 1/1/11",
               resp_valid, resp_id, resp_data);
    end
    step();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp_end: valid=%b, want 0", resp_valid);
    end
  endtask

  task automatic test_full_contention();
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      step();
      req_valid = (c < 5) ? 4'hF : 4'h0;
      req_data  = 32'hA3A2_A1A0;
      #1;
      if (c < 5) begin
        n_cmp++;
        if (req_ready !== 4'(1 << exp_g[c]) || pipe_in !== 8'(8'hA0 + exp_g[c])) begin
          n_fail++;
          $display("FAIL contention_grant_c%0d: ready=%b pipe_in=%h, want grant %0d data %h",
                   c, req_ready, pipe_in, exp_g[c], 8'(8'hA0 + exp_g[c]));
        end
      end
      if (c >= 3 && c < 8) begin
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 2'(exp_g[c-3]) ||
            resp_data !== 8'(8'hA0 + exp_g[c-3])) begin
          n_fail++;
          $display("FAIL contention_resp_c%0d: valid=%b id=%0d data=%h, want 1/%0d/%h",
                   c, resp_valid, resp_id, resp_data, exp_g[c-3], 8'(8'hA0 + exp_g[c-3]));
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL contention_drain: valid=%b, want 0", resp_valid);
        end
      end
    end
    n_cmp++;
    if (issued_count !== 16'd5) begin
      n_fail++;
      $display("FAIL contention_count: count=%0d, want 5", issued_count);
    end
  endtask

  // Pointer is 1 on entry (last contention grant went to requester 0).
  task automatic test_ptr_wrap();
    int exp_id[3];
    exp_id = '{3, 0, 2};
    step();
    req_valid = 4'b1000;
    req_data  = 32'h3300_0000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000 || pipe_in !== 8'h33) begin
      n_fail++;
      $display("FAIL wrap_grant3: ready=%b pipe_in=%h, want 1000/33", req_ready, pipe_in);
    end
    step();
    req_valid = 4'b0101;
    req_data  = 32'h0012_0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001 || pipe_in !== 8'h10) begin
      n_fail++;
      $display("FAIL wrap_grant0: ready=%b pipe_in=%h, want 0001/10", req_ready, pipe_in);
    end
    step();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100 || pipe_in !== 8'h12) begin
      n_fail++;
      $display("FAIL wrap_grant2: ready=%b pipe_in=%h, want 0100/12", req_ready, pipe_in);
    end
    for (int w = 3; w < 6; w++) begin
      step();
      req_valid = '0;
      #1;
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(exp_id[w-3])) begin
        n_fail++;
        $display("FAIL wrap_resp_w%0d: valid=%b id=%0d, want 1/%0d",
                 w, resp_valid, resp_id, exp_id[w-3]);
      end
    end
  endtask

  // Pointer is 3 on entry.
  task automatic test_enable_gap();
    logic iss_v[7];
    int   iss_id[7];
    iss_v  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    iss_id = '{3, 0, 0, 0, 1, 2, 0};
    for (int c = 0; c < 10; c++) begin
      step();
      req_valid = (c < 6) ? 4'hF : 4'h0;
      enable    = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      req_data  = 32'hB3B2_B1B0;
      #1;
      if (c < 6) begin
        n_cmp++;
        if (req_ready !== (iss_v[c] ? 4'(1 << iss_id[c]) : 4'h0) || pipe_valid !== iss_v[c]) begin
          n_fail++;
          $display("FAIL gap_grant_c%0d: ready=%b valid=%b, want valid %b id %0d",
                   c, req_ready, pipe_valid, iss_v[c], iss_id[c]);
        end
      end
      if (c >= 3) begin
        n_cmp++;
        if (resp_valid !== iss_v[c-3] ||
            (iss_v[c-3] && (resp_id !== 2'(iss_id[c-3]) ||
                            resp_data !== 8'(8'hB0 + iss_id[c-3])))) begin
          n_fail++;
          $display("FAIL gap_resp_c%0d: valid=%b id=%0d data=%h, want valid %b id %0d",
                   c, resp_valid, resp_id, resp_data, iss_v[c-3], iss_id[c-3]);
        end
      end
    end
    enable = 1'b1;
  endtask

  // Pointer is 3 on entry.
  task automatic test_reset_mid_flight();
    step();
    req_valid = 4'hF;
    req_data  = 32'hC3C2_C1C0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrst_issue0: ready=%b, want 1000", req_ready);
    end
    step();
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_issue1: ready=%b, want 0001", req_ready);
    end
    step();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || issued_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%b count=%0d, want 0/0", resp_valid, issued_count);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_drop_c%0d: valid=%b, want 0", c, resp_valid);
      end
      step();
    end
    req_valid = 4'hF;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001 || pipe_in !== 8'hC0) begin
      n_fail++;
      $display("FAIL midrst_regrant: ready=%b pipe_in=%h, want 0001/c0", req_ready, pipe_in);
    end
    step();
    req_valid = '0;
    #1;
    n_cmp++;
    if (issued_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_count: count=%0d, want 1", issued_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_contention();
    test_ptr_wrap();
    test_enable_gap();
    test_reset_mid_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
